serial_adder: RTL and testbench

//  Parametrised multi-cycle add/subtract unit. It processes DIGIT bits per cycle over WIDTH/DIGIT

---
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: DIGIT bits per cycle over WIDTH/DIGIT cycles, registered carry,
// valid/ready handshakes on both sides, one operation in flight.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dig;
    logic             c_msb;
    logic             accept;
    logic             last;

    assign dig   = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + (DIGIT+1)'(carry);
    // Carry into the top bit of this digit, recovered from that bit's sum and operands.
    assign c_msb = dig[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];

    generate
        if (WIDTH == DIGIT) begin : g_single
            assign res_next = dig[DIGIT-1:0];
        end else begin : g_multi
            assign res_next = {dig[DIGIT-1:0], res[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                last = (cnt == '0);
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction runs as a + ~b + ~cin.
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= CW'(NDIG - 1);
        end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            res   <= res_next;
            carry <= dig[DIGIT];
            if (last) begin
                sum  <= res_next;
                cout <= dig[DIGIT];
                ovf  <= c_msb ^ dig[DIGIT];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (8/1, 16/4, 1/1) driven one at a time through a
// shared stimulus bus, checked against an arithmetic reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, isub, icin, ordy;
    logic [15:0] ia, ib;
    int          cur;

    logic        ir8, ov8, co8, of8, bz8;
    logic [7:0]  s8;
    logic        ir16, ov16, co16, of16, bz16;
    logic [15:0] s16;
    logic        ir1, ov1, co1, of1, bz1;
    logic [0:0]  s1;

    logic        m_ir, m_ov, m_busy, m_cout, m_ovf;
    logic [15:0] m_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv && cur == 0), .in_ready(ir8),
        .a(ia[7:0]), .b(ib[7:0]), .sub(isub), .cin(icin),
        .out_valid(ov8), .out_ready(ordy), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv && cur == 1), .in_ready(ir16),
        .a(ia), .b(ib), .sub(isub), .cin(icin),
        .out_valid(ov16), .out_ready(ordy), .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
    );

    serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv && cur == 2), .in_ready(ir1),
        .a(ia[0:0]), .b(ib[0:0]), .sub(isub), .cin(icin),
        .out_valid(ov1), .out_ready(ordy), .sum(s1), .cout(co1), .ovf(of1), .busy(bz1)
    );

    always_comb begin
        m_ir = ir8; m_ov = ov8; m_busy = bz8; m_sum = {8'h00, s8}; m_cout = co8; m_ovf = of8;
        case (cur)
            1: begin
                m_ir = ir16; m_ov = ov16; m_busy = bz16; m_sum = s16; m_cout = co16; m_ovf = of16;
            end
            2: begin
                m_ir = ir1; m_ov = ov1; m_busy = bz1; m_sum = {15'h0, s1}; m_cout = co1; m_ovf = of1;
            end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    function automatic int wid(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 1;
    endfunction

    function automatic int ndig(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin,
                         output logic [15:0] s, output logic co, output logic ov);
        longint m, ua, ub, sa, sb, ci, ur, sr;
        m  = longint'(1) << wid(sel);
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ci = cin ? 1 : 0;
        if (!sub) begin
            ur = ua + ub + ci;
            sr = sa + sb + ci;
            co = (ur >= m);
        end else begin
            ur = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ur >= 0);
        end
        s  = 16'(((ur % m) + m) % m);
        ov = (sr < -(m / 2)) || (sr >= m / 2);
    endtask

    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input int hold,
                          output logic [15:0] s, output logic co, output logic ov);
        int n;
        int lat;
        cur = sel; ia = a; ib = b; isub = sub; icin = cin; iv = 1'b1; ordy = 1'b0;
        #1;
        n = 0;
        while (!m_ir && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        iv = 1'b0; ia = 16'($urandom); ib = 16'($urandom); isub = 1'($urandom); icin = 1'($urandom);
        chk("run_flags", {29'h0, m_busy, m_ir, m_ov}, 32'b100);
        lat = 0;
        while (!m_ov && lat < 100) begin
            ordy = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, ndig(sel));
        ordy = 1'b0;
        s = m_sum; co = m_cout; ov = m_ovf;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        chk("hold_valid", {31'h0, m_ov}, 32'h1);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("post_hs", {30'h0, m_ov, m_ir}, 32'b01);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] s, es;
        logic        co, ov, eco, eov;
        int          n;

        vecs[0] = '{0, 16'h0F,   16'h01,   1'b0, 1'b0, 16'h10,   1'b0, 1'b0};
        vecs[1] = '{0, 16'hFF,   16'h01,   1'b0, 1'b0, 16'h00,   1'b1, 1'b0};
        vecs[2] = '{0, 16'h7F,   16'h01,   1'b0, 1'b0, 16'h80,   1'b0, 1'b1};
        vecs[3] = '{0, 16'h05,   16'h07,   1'b1, 1'b0, 16'hFE,   1'b0, 1'b0};
        vecs[4] = '{0, 16'h80,   16'h01,   1'b1, 1'b0, 16'h7F,   1'b1, 1'b1};
        vecs[5] = '{1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[6] = '{1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1};

        rst = 1'b1; iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; isub = 1'b0; icin = 1'b0; cur = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur = k; #1;
            chk($sformatf("reset_state%0d", k),
                {10'h0, m_ir, m_ov, m_busy, m_sum, m_cout, m_ovf}, {10'h0, 3'b100, 16'h0, 2'b00});
        end

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, i % 3, s, co, ov);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            chk($sformatf("vec%0d_cout_ovf", i), {co, ov}, {vecs[i].cout, vecs[i].ovf});
        end

        // Backpressure with in_valid pulses during DONE
        cur = 0; ia = 16'h0F; ib = 16'h01; isub = 1'b0; icin = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        n = 0;
        while (!m_ov && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", n, 8);
        for (int k = 0; k < 5; k++) begin
            iv = (k == 1 || k == 2); ia = 16'h33; ib = 16'h44;
            @(posedge clk); #1;
            chk("bp_hold", {13'h0, m_ov, m_ir, m_busy, m_sum}, {13'h0, 3'b101, 16'h0010});
        end
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("bp_release", {13'h0, m_ov, m_ir, m_busy, m_sum}, {13'h0, 3'b010, 16'h0010});
        repeat (3) @(posedge clk);
        #1 chk("bp_no_capture", {30'h0, m_ov, m_busy}, 32'h0);

        // Reset on the 3rd RUN cycle
        cur = 0; ia = 16'hAA; ib = 16'h55; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_run", {10'h0, m_ir, m_ov, m_busy, m_sum, m_cout, m_ovf},
            {10'h0, 3'b100, 16'h0, 2'b00});
        run_op(0, 16'h12, 16'h34, 1'b0, 1'b0, 0, s, co, ov);
        chk("after_rst_sum", {s, co, ov}, {16'h0046, 2'b00});

        // W=D=1 exhaustive
        for (int x = 0; x < 16; x++) begin
            logic [3:0] bits;
            bits = 4'(x);
            model(2, {15'h0, bits[0]}, {15'h0, bits[1]}, bits[3], bits[2], es, eco, eov);
            run_op(2, {15'h0, bits[0]}, {15'h0, bits[1]}, bits[3], bits[2], 0, s, co, ov);
            chk($sformatf("w1_combo%0d", x), {s, co, ov}, {es, eco, eov});
        end

        for (int i = 0; i < 1000; i++) begin
            int          sel;
            logic [15:0] ra, rb;
            logic        rs, rc;
            sel = $urandom_range(0, 2);
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            model(sel, ra, rb, rs, rc, es, eco, eov);
            run_op(sel, ra, rb, rs, rc, $urandom_range(0, 3), s, co, ov);
            chk($sformatf("rand%0d_sel%0d", i, sel), {s, co, ov}, {es, eco, eov});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
